// File: rtl/rng_fetch_arbiter_pkg.sv
// Shared definitions for the random-number fetch arbiter: FSM encoding,
// BCD digit geometry and the digit-range check used on captured samples.
package rng_defs;

  localparam int DIGIT_W = 4;
  localparam int DATA_W  = 16;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_CHECK   = 3'd3,
    S_DELIVER = 3'd4
  } state_t;

  // True when every nibble of the captured word is a legal decimal digit.
  function automatic logic bcd_ok(input logic [DATA_W-1:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DATA_W / DIGIT_W; i++) begin
      if (w[i*DIGIT_W +: DIGIT_W] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/rng_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after the
// pointer, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] pointer,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    k         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = IDX_W'((int'(pointer) + i) % NUM_REQ);
      if (!any && req[k]) begin
        any       = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = k;
      end
    end
  end

endmodule

// File: rtl/rng_fetch_arbiter.sv
// Shares one random-number core between NUM_REQ requesters: round-robin grant,
// fetch pulse, fixed capture wait, BCD check with bounded refetch, delivery.
module rng_fetch_arbiter
  import rng_defs::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int FETCH_LAT = 2,
  parameter int MAX_RETRY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [DATA_W-1:0]  data_out,
  output logic               data_valid,
  output logic               data_err,
  output logic               busy,
  output logic               rng_fetch,
  input  logic [DIGIT_W-1:0] rng_d1000,
  input  logic [DIGIT_W-1:0] rng_d100,
  input  logic [DIGIT_W-1:0] rng_d10,
  input  logic [DIGIT_W-1:0] rng_d1
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_W   = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     grant_idx_q;
  logic [NUM_REQ-1:0]   grant_oh_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [RETRY_W-1:0]   retry_q;
  logic [DATA_W-1:0]    sample_q;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic                 sample_ok;
  logic                 retry_left;
  logic                 deliver_now;
  logic                 req_live;

  logic [NUM_REQ-1:0]   ack_d;
  logic                 valid_d;
  logic                 err_d;
  logic                 fetch_d;
  logic                 busy_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req       (req),
    .pointer   (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign sample_ok  = bcd_ok(sample_q);
  assign retry_left = (int'(retry_q) < MAX_RETRY);
  assign req_live   = |(req & grant_oh_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (arb_any) state_d = S_FETCH;
      S_FETCH:   state_d = S_WAIT;
      S_WAIT:    if (cnt_q == '0) state_d = S_CHECK;
      S_CHECK: begin
        if (sample_ok)       state_d = S_DELIVER;
        else if (retry_left) state_d = S_FETCH;
        else                 state_d = S_DELIVER;
      end
      S_DELIVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so they register in step with it.
  always_comb begin
    deliver_now = (state_q == S_CHECK) && (state_d == S_DELIVER);
    valid_d     = deliver_now && req_live;
    ack_d       = valid_d ? grant_oh_q : '0;
    err_d       = valid_d && !sample_ok;
    fetch_d     = (state_d == S_FETCH);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack        <= '0;
      data_valid <= 1'b0;
      data_err   <= 1'b0;
      rng_fetch  <= 1'b0;
      busy       <= 1'b0;
      data_out   <= '0;
    end else begin
      ack        <= ack_d;
      data_valid <= valid_d;
      data_err   <= err_d;
      rng_fetch  <= fetch_d;
      busy       <= busy_d;
      if (valid_d) data_out <= sample_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
      cnt_q       <= '0;
      retry_q     <= '0;
      sample_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arb_any) begin
            grant_idx_q <= arb_idx;
            grant_oh_q  <= arb_grant;
          end
        end
        S_FETCH: cnt_q <= CNT_W'(FETCH_LAT - 1);
        S_WAIT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else             sample_q <= {rng_d1000, rng_d100, rng_d10, rng_d1};
        end
        S_CHECK: begin
          if (!sample_ok && retry_left) retry_q <= retry_q + 1'b1;
        end
        S_DELIVER: begin
          ptr_q   <= (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
          retry_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_fetch_arbiter.sv
// Scoreboard bench for rng_fetch_arbiter: a transaction-level model plans grant
// order, core samples and cycle timing; a monitor checks fetches and deliveries.
module tb_rng_fetch_arbiter;

  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int RETRY = 1;

  typedef struct {
    int          cyc;
    logic [3:0]  ack;
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_err;
  logic        busy;
  logic        rng_fetch;
  logic [3:0]  rng_d1000, rng_d100, rng_d10, rng_d1;

  int          cyc;
  int          n_checks;
  int          n_fail;
  bit          sb_en;
  int          model_ptr;
  logic [15:0] last_data;

  exp_t        exp_q[$];
  int          fetch_q[$];
  logic [15:0] core_q[$];
  logic [15:0] dir_q[$];

  rng_fetch_arbiter #(
    .NUM_REQ   (NREQ),
    .FETCH_LAT (LAT),
    .MAX_RETRY (RETRY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ack        (ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_err   (data_err),
    .busy       (busy),
    .rng_fetch  (rng_fetch),
    .rng_d1000  (rng_d1000),
    .rng_d100   (rng_d100),
    .rng_d10    (rng_d10),
    .rng_d1     (rng_d1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit digits_ok(input logic [15:0] w);
    for (int d = 0; d < 4; d++)
      if (((w >> (4 * d)) & 16'hF) > 9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] next_sample();
    logic [15:0] w;
    if (dir_q.size() > 0) return dir_q.pop_front();
    w = '0;
    for (int d = 0; d < 4; d++)
      w = (w << 4) | 16'(($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9));
    return w;
  endfunction

  // One grant, request seen at the edge after cycle s; returns the next start point.
  task automatic plan_grant(input int idx, input int s, output int s_next);
    logic [15:0] w;
    bit          ok;
    int          a;
    a = 0;
    forever begin
      w = next_sample();
      core_q.push_back(w);
      fetch_q.push_back(s + 1 + (2 + LAT) * a);
      ok = digits_ok(w);
      if (ok || a == RETRY) break;
      a++;
    end
    exp_q.push_back('{cyc: s + 3 + LAT + (2 + LAT) * a, ack: 4'(1 << idx), data: w, err: !ok});
    last_data = w;
    s_next = s + 4 + LAT + (2 + LAT) * a;
  endtask

  task automatic run_episode(input logic [3:0] mask);
    int order[$];
    int s;
    int budget;
    s = cyc;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (model_ptr + i) % NREQ;
      if (mask[k]) order.push_back(k);
    end
    foreach (order[j]) begin
      plan_grant(order[j], s, s);
      model_ptr = (order[j] + 1) % NREQ;
    end
    req = req | mask;
    budget = 0;
    while (req != 0 && budget < 400) begin
      @(negedge clk);
      req = req & ~ack;
      budget++;
    end
    check("episode_complete", {28'h0, req}, 32'h0);
    req = '0;
    @(negedge clk);
  endtask

  // Monitor plus core model: supplies planned digits on each fetch and scores outputs.
  initial begin
    exp_t e;
    logic [15:0] w;
    {rng_d1000, rng_d100, rng_d10, rng_d1} = 16'h0;
    forever begin
      @(negedge clk);
      if (rng_fetch) begin
        w = (core_q.size() > 0) ? core_q.pop_front() : 16'h0;
        {rng_d1000, rng_d100, rng_d10, rng_d1} = w;
      end
      if (sb_en) begin
        if (rng_fetch) begin
          if (fetch_q.size() == 0) check("unexpected_fetch", 32'(cyc), 32'hFFFF_FFFF);
          else check("fetch_cycle", 32'(cyc), 32'(fetch_q.pop_front()));
        end
        if (ack != 0 || data_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ack", {27'h0, data_valid, ack}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            check("ack", {28'h0, ack}, {28'h0, e.ack});
            check("data_valid", {31'h0, data_valid}, 32'h1);
            check("data_out", {16'h0, data_out}, {16'h0, e.data});
            check("data_err", {31'h0, data_err}, {31'h0, e.err});
            check("ack_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, {28'h0, ack}, 32'h0);
    check({tag, "_data_valid"}, {31'h0, data_valid}, 32'h0);
    check({tag, "_data_err"}, {31'h0, data_err}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_rng_fetch"}, {31'h0, rng_fetch}, 32'h0);
    check({tag, "_data_out"}, {16'h0, data_out}, 32'h0);
  endtask

  initial begin
    int s;
    n_checks  = 0;
    n_fail    = 0;
    sb_en     = 1'b0;
    model_ptr = 0;
    last_data = '0;
    rst       = 1'b1;
    req       = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted while req[1] is mid-WAIT.
    req = 4'b0010;
    repeat (2) @(negedge clk);
    check("busy_before_reset", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    dir_q.push_back(16'h9009);
    rst   = 1'b0;
    sb_en = 1'b1;
    run_episode(4'b0010);

    // Single request, known digits.
    dir_q.push_back(16'h4702);
    run_episode(4'b0001);

    // Invalid ones digit first, valid on the refetch.
    dir_q.push_back(16'h123C);
    dir_q.push_back(16'h1235);
    run_episode(4'b0001);

    // Invalid on both samples, then a grant that must still get its retry.
    dir_q.push_back(16'h12F4);
    dir_q.push_back(16'h12F4);
    run_episode(4'b0010);
    dir_q.push_back(16'h5A00);
    dir_q.push_back(16'h5600);
    run_episode(4'b0100);

    // Pointer to 0, then all four at once, then req[0] alone.
    run_episode(4'b1000);
    run_episode(4'b1111);
    run_episode(4'b0001);

    // req[2] withdrawn during WAIT: result discarded, pointer still advances.
    s = cyc;
    core_q.push_back(16'h2468);
    fetch_q.push_back(s + 1);
    req = 4'b0100;
    model_ptr = 3;
    repeat (2) @(negedge clk);
    req = '0;
    repeat (LAT + 4) @(negedge clk);
    check("hold_data_out", {16'h0, data_out}, {16'h0, last_data});
    check("idle_after_drop", {31'h0, busy}, 32'h0);
    run_episode(4'b1100);

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      run_episode(4'($urandom_range(1, 15)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("pending_deliveries", 32'(exp_q.size()), 32'h0);
    check("pending_fetches", 32'(fetch_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
